// File: rtl/keccak_stream_padder.sv
// Keccak pad10*1 stream padder: packs W-bit message words into rate blocks
// and hands each block to the permutation core over a valid/ack handshake.
module keccak_stream_padder #(
  parameter int          W          = 64,
  parameter int          RATE_WORDS = 9,
  parameter logic [7:0]  PAD_BYTE   = 8'h01,
  parameter logic [7:0]  FINAL_BYTE = 8'h80,
  parameter int          BN_W       = $clog2(W/8)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [W-1:0]            in,
  input  logic                    in_valid,
  input  logic                    is_last,
  input  logic [BN_W-1:0]         byte_num,
  output logic                    in_ready,
  output logic [W*RATE_WORDS-1:0] out,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ack
);

  // state | meaning
  // FILL  | accepting message words
  // PAD   | writing zero words up to the end of the block
  // FULL  | block presented, waiting for out_ack
  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_PAD  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  localparam int NB = W / 8;
  localparam int CW = $clog2(RATE_WORDS + 1);
  localparam int IW = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_valid;
  logic          r_last;
  logic [W-1:0]  r_words [RATE_WORDS];

  logic [W-1:0]  w_last_word;
  logic [W-1:0]  w_final_word;
  logic          w_at_end;
  logic [IW-1:0] w_idx;

  assign w_at_end     = (r_cnt == CW'(RATE_WORDS - 1));
  assign w_idx        = r_cnt[IW-1:0];
  assign w_final_word = {{(W-8){1'b0}}, FINAL_BYTE};

  // Keep bytes below byte_num, drop the pad byte after them, zero the rest.
  always_comb begin
    w_last_word = '0;
    for (int b = 0; b < NB; b++) begin
      if (BN_W'(b) < byte_num)
        w_last_word[W-1-8*b -: 8] = in[W-1-8*b -: 8];
      else if (BN_W'(b) == byte_num)
        w_last_word[W-1-8*b -: 8] = PAD_BYTE;
    end
  end

  assign in_ready = (r_state == S_FILL) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FILL;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      for (int i = 0; i < RATE_WORDS; i++) r_words[i] <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (in_valid) begin
            r_cnt <= r_cnt + CW'(1);
            if (!is_last) begin
              r_words[w_idx] <= in;
              if (w_at_end) begin
                r_state <= S_FULL;
                r_valid <= 1'b1;
                r_last  <= 1'b0;
              end
            end else if (w_at_end) begin
              r_words[w_idx] <= w_last_word | w_final_word;
              r_state        <= S_FULL;
              r_valid        <= 1'b1;
              r_last         <= 1'b1;
            end else begin
              r_words[w_idx] <= w_last_word;
              r_state        <= S_PAD;
            end
          end
        end
        S_PAD: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_at_end) begin
            r_words[w_idx] <= w_final_word;
            r_state        <= S_FULL;
            r_valid        <= 1'b1;
            r_last         <= 1'b1;
          end else begin
            r_words[w_idx] <= '0;
          end
        end
        S_FULL: begin
          if (out_ack) begin
            r_state <= S_FILL;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_FILL;
          r_cnt   <= '0;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  // Word 0 occupies the most significant W bits of the block.
  for (genvar g = 0; g < RATE_WORDS; g++) begin : g_out
    assign out[W*(RATE_WORDS-g)-1 -: W] = r_words[g];
  end

  assign out_valid = r_valid;
  assign out_last  = r_last;

endmodule

// File: tb/tb_keccak_stream_padder.sv
// Directed bench for keccak_stream_padder at W=64, RATE_WORDS=9 with
// hand-computed padded blocks.
module tb_keccak_stream_padder;

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   tb_in;
  logic          in_valid;
  logic          is_last;
  logic [2:0]    byte_num;
  logic          in_ready;
  logic [575:0]  out;
  logic          out_valid;
  logic          out_last;
  logic          out_ack;

  int total = 0;
  int bad   = 0;

  keccak_stream_padder #(.W(64), .RATE_WORDS(9)) dut (
    .clk(clk), .reset(reset), .in(tb_in), .in_valid(in_valid),
    .is_last(is_last), .byte_num(byte_num), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .out_last(out_last), .out_ack(out_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [63:0] d, input logic l, input logic [2:0] n);
    int g = 0;
    while (!in_ready && g < 50) begin tick(); g++; end
    total++;
    if (g >= 50) begin bad++; $display("FAIL send_timeout in_ready=%b required=1", in_ready); end
    tb_in = d; in_valid = 1'b1; is_last = l; byte_num = n;
    tick();
    in_valid = 1'b0; is_last = 1'b0; byte_num = 3'd0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 100) begin tick(); cycles++; end
  endtask

  task automatic do_ack();
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ack_release out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'hA5A5_0000_0000_5A5A ^ (64'h0001_0203_0405_0000 * 64'(i + 1));
  endfunction

  task automatic test_reset();
    reset = 1'b1; tb_in = '0; in_valid = 1'b0; is_last = 1'b0; byte_num = '0; out_ack = 1'b0;
    tick(); tick();
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b required=0", in_ready); end
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out !== '0) begin
      bad++;
      $display("FAIL reset_state in_ready=%b out_valid=%b out_last=%b out=%h", in_ready, out_valid, out_last, out);
    end
    // A stray ack while nothing is presented must not disturb anything.
    out_ack = 1'b1; tick(); out_ack = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL stray_ack in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_empty();
    int c;
    logic [575:0] e;
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd0);
    wait_valid(c);
    e = {64'h0100000000000000, {7{64'h0}}, 64'h0000000000000080};
    total++;
    if (c != 8) begin bad++; $display("FAIL empty_latency got=%0d required=8", c); end
    total++;
    if (out !== e || out_last !== 1'b1) begin
      bad++; $display("FAIL empty_block got=%h last=%b required=%h last=1", out, out_last, e);
    end
    do_ack();
  endtask

  task automatic test_three_bytes();
    int c;
    logic [575:0] e;
    send_word(64'hAABBCC_1122334455, 1'b1, 3'd3);
    wait_valid(c);
    e = {64'hAABBCC0100000000, {7{64'h0}}, 64'h0000000000000080};
    total++;
    if (c != 8) begin bad++; $display("FAIL three_latency got=%0d required=8", c); end
    total++;
    if (out !== e || out_last !== 1'b1) begin
      bad++; $display("FAIL three_block got=%h last=%b required=%h last=1", out, out_last, e);
    end
    do_ack();
  endtask

  task automatic test_block_end();
    int c;
    logic [575:0] e;
    for (int i = 0; i < 8; i++) begin
      send_word(pat(i), 1'b0, 3'd0);
      e[64*(9-i)-1 -: 64] = pat(i);
    end
    send_word(64'h0102030405060708, 1'b1, 3'd7);
    e[63:0] = 64'h0102030405060781;
    wait_valid(c);
    total++;
    if (c != 0) begin bad++; $display("FAIL block_end_latency got=%0d required=0", c); end
    total++;
    if (out !== e || out_last !== 1'b1) begin
      bad++; $display("FAIL block_end got=%h last=%b required=%h last=1", out, out_last, e);
    end
    do_ack();
  endtask

  task automatic test_multi_block();
    int c;
    logic [575:0] e;
    for (int i = 0; i < 9; i++) begin
      send_word(pat(i + 10), 1'b0, 3'd0);
      e[64*(9-i)-1 -: 64] = pat(i + 10);
    end
    wait_valid(c);
    total++;
    if (c != 0 || out_last !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL multi_first_flags lat=%0d last=%b in_ready=%b required 0/0/0", c, out_last, in_ready);
    end
    total++;
    if (out !== e) begin bad++; $display("FAIL multi_first_block got=%h required=%h", out, e); end
    tick(); tick();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL multi_hold in_ready=%b out_valid=%b required 0/1", in_ready, out_valid);
    end
    do_ack();
    send_word(pat(30), 1'b0, 3'd0);
    send_word(pat(31), 1'b0, 3'd0);
    send_word(64'h7777_7777_7777_7777, 1'b1, 3'd0);
    wait_valid(c);
    e = {pat(30), pat(31), 64'h0100000000000000, {5{64'h0}}, 64'h0000000000000080};
    total++;
    if (c != 6) begin bad++; $display("FAIL multi_second_latency got=%0d required=6", c); end
    total++;
    if (out !== e || out_last !== 1'b1) begin
      bad++; $display("FAIL multi_second_block got=%h last=%b required=%h last=1", out, out_last, e);
    end
    do_ack();
  endtask

  task automatic test_backpressure();
    int c;
    int errs = 0;
    logic [575:0] held;
    for (int i = 0; i < 9; i++) send_word(pat(i + 50), 1'b0, 3'd0);
    wait_valid(c);
    held = out;
    tb_in = 64'hDEAD_BEEF_DEAD_BEEF; in_valid = 1'b1; is_last = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (in_ready !== 1'b0 || out !== held || out_valid !== 1'b1) begin
        bad++; errs++;
        if (errs < 4) $display("FAIL backpressure cyc=%0d in_ready=%b valid=%b out=%h required=%h", i, in_ready, out_valid, out, held);
      end
    end
    in_valid = 1'b0;
    do_ack();
  endtask

  task automatic test_reset_mid();
    int c;
    logic [575:0] e;
    send_word(64'h0, 1'b1, 3'd0);
    tick(); tick();
    reset = 1'b1; tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_pad out_valid=%b in_ready=%b required 0/0", out_valid, in_ready);
    end
    reset = 1'b0; #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_pad_release in_ready=%b required=1", in_ready); end
    send_word(64'h1234_5678_9ABC_DEF0, 1'b1, 3'd1);
    wait_valid(c);
    e = {64'h1201000000000000, {7{64'h0}}, 64'h0000000000000080};
    total++;
    if (c != 8 || out !== e) begin
      bad++; $display("FAIL after_pad_reset lat=%0d got=%h required lat=8 %h", c, out, e);
    end
    do_ack();
    for (int i = 0; i < 9; i++) send_word(pat(i + 70), 1'b0, 3'd0);
    wait_valid(c);
    reset = 1'b1; tick();
    total++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out !== '0) begin
      bad++; $display("FAIL reset_full out_valid=%b out_last=%b out=%h required 0/0/zero", out_valid, out_last, out);
    end
    reset = 1'b0; #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_full_release in_ready=%b required=1", in_ready); end
    send_word(64'hDEAD_0000_1111_2222, 1'b1, 3'd2);
    wait_valid(c);
    e = {64'hDEAD010000000000, {7{64'h0}}, 64'h0000000000000080};
    total++;
    if (c != 8 || out !== e || out_last !== 1'b1) begin
      bad++; $display("FAIL after_full_reset lat=%0d got=%h required lat=8 %h", c, out, e);
    end
    do_ack();
  endtask

  initial begin
    test_reset();
    test_empty();
    test_three_bytes();
    test_block_end();
    test_multi_block();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
